prefetch_queue: RTL and testbench

- Parametrised instruction-byte prefetcher between program memory and the decoder; successor to the single-byte fetcher.
- Keeps a fetch address and issues sequential reads to a synchronous-read memory (1-cycle latency). Returned bytes go into a DEPTH-entry FIFO; each entry carries its source address.
- The decoder consumes bytes through a valid/ready handshake.
- `flush` redirects fetching (program start, jumps, branches) and discards all buffered and in-flight bytes.

---
 rtl/prefetch_queue.sv | 173 +++++++++++++++++
 tb/tb_prefetch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_queue
// Description : Instruction-byte prefetcher. Issues sequential reads to a
//               1-cycle-latency synchronous memory and buffers the returned
//               bytes (with their source addresses) in a DEPTH-entry FIFO
//               that the decoder drains through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [ADDR_WIDTH-1:0]    flush_addr,
    input  logic                     hold,
    output logic                     mem_re,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_WIDTH-1:0]    fetch_pc
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    // One extra bit so count + inflight + outstanding never overflows.
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DATA_WIDTH-1:0]  r_data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_addr_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;

    logic                   r_mem_re;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    // Data for the read issued last cycle arrives this cycle.
    logic                   r_inflight;
    logic [ADDR_WIDTH-1:0]  r_inflight_addr;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_issue;
    logic [c_cnt_w:0]       w_used;

    // Flush wins over both queue operations.
    assign w_pop  = (r_count != '0) && out_ready && !flush;
    assign w_push = r_inflight && !flush;

    // Slots already committed: buffered, arriving now, arriving next cycle,
    // less the one being freed by a pop this cycle.
    assign w_used = {1'b0, r_count}
                  + {{c_cnt_w{1'b0}}, r_inflight}
                  + {{c_cnt_w{1'b0}}, r_mem_re}
                  - {{c_cnt_w{1'b0}}, w_pop};

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!flush && !hold && (w_used < c_depth)) begin
                    w_issue = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch address, memory strobe and in-flight tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_re        <= 1'b0;
            r_mem_addr      <= '0;
            r_fetch_pc      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (flush) begin
            r_mem_re        <= 1'b0;
            r_fetch_pc      <= flush_addr;
            r_inflight      <= 1'b0;
        end else begin
            r_mem_re        <= w_issue;
            r_inflight      <= r_mem_re;
            r_inflight_addr <= r_mem_addr;
            if (w_issue) begin
                r_mem_addr <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data_mem[i] <= '0;
                r_addr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_data_mem[r_wr_ptr] <= mem_rdata;
            r_addr_mem[r_wr_ptr] <= r_inflight_addr;
        end
    end

    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign fetch_pc  = r_fetch_pc;
    assign count     = r_count;
    assign out_valid = (r_count != '0);
    assign out_data  = r_data_mem[r_rd_ptr];
    assign out_addr  = r_addr_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_queue
// Description : Self-checking bench for prefetch_queue: table-driven stream
//               and wrap vectors plus directed backpressure, flush, hold and
//               mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] flush_addr;
    logic        hold;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        out_ready;
    logic [2:0]  count;
    logic [15:0] fetch_pc;

    int n_pass  = 0;
    int n_total = 0;
    int overflow_hits = 0;

    prefetch_queue #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
        .hold(hold), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
        .out_addr(out_addr), .out_ready(out_ready), .count(count),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hA9;
            16'h0011: return 8'h04;
            16'h0012: return 8'h85;
            16'h0013: return 8'h02;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Synchronous-read program memory, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_byte(mem_addr);
    end

    // A push into a full queue without a simultaneous pop must never happen.
    always @(posedge clk) begin
        if (!reset && dut.w_push && !dut.w_pop && count == 3'(DEPTH))
            overflow_hits = overflow_hits + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_next;

    // Every byte presented while out_ready=1 must be the next sequential one.
    task automatic track();
        if (out_valid) begin
            check("stream.addr", {16'h0, out_addr}, {16'h0, exp_next});
            check("stream.data", {24'h0, out_data}, {24'h0, mem_byte(exp_next)});
            exp_next = exp_next + 16'd1;
        end
    endtask

    typedef struct {
        logic        flush;
        logic [15:0] faddr;
        logic        ev;
        logic [7:0]  ed;
        logic [15:0] ea;
        logic [2:0]  ec;
        logic        ere;
        logic [15:0] ema;
        logic [15:0] epc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n_reads;
        int steps;
        int bad;
        logic [15:0] frozen;

        // Stream from 0x0010 with the decoder always ready.
        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0010};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b1, 16'h0010, 16'h0011};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b1, 16'h0011, 16'h0012};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 8'hA9, 16'h0010, 3'd1, 1'b1, 16'h0012, 16'h0013};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 8'h04, 16'h0011, 3'd1, 1'b1, 16'h0013, 16'h0014};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 8'h85, 16'h0012, 3'd1, 1'b1, 16'h0014, 16'h0015};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 8'h02, 16'h0013, 3'd1, 1'b1, 16'h0015, 16'h0016};
        // Redirect mid-stream to 0xFFFE: address wraps through 0x0000.
        vecs[7]  = '{1'b1, 16'hFFFE, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'hFFFE};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b1, 16'hFFFE, 16'hFFFF};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 1'b1, 16'hFFFF, 16'h0000};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 8'hA4, 16'hFFFE, 3'd1, 1'b1, 16'h0000, 16'h0001};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 8'hA5, 16'hFFFF, 3'd1, 1'b1, 16'h0001, 16'h0002};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 8'h5A, 16'h0000, 3'd1, 1'b1, 16'h0002, 16'h0003};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 8'h5B, 16'h0001, 3'd1, 1'b1, 16'h0003, 16'h0004};

        reset = 1'b1; flush = 1'b0; flush_addr = 16'h0; hold = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("reset.valid",   {31'h0, out_valid}, 32'h0);
        check("reset.count",   {29'h0, count},     32'h0);
        check("reset.mem_re",  {31'h0, mem_re},    32'h0);
        check("reset.pc",      {16'h0, fetch_pc},  32'h0);
        check("reset.data",    {24'h0, out_data},  32'h0);
        check("reset.addr",    {16'h0, out_addr},  32'h0);
        reset = 1'b0;
        step();
        step();
        check("idle.mem_re", {31'h0, mem_re}, 32'h0);

        // Table-driven stream and wrap vectors.
        for (int i = 0; i < 14; i++) begin
            flush      = vecs[i].flush;
            flush_addr = vecs[i].faddr;
            step();
            check($sformatf("row%0d.valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
            check($sformatf("row%0d.count", i), {29'h0, count},     {29'h0, vecs[i].ec});
            check($sformatf("row%0d.mem_re", i), {31'h0, mem_re},   {31'h0, vecs[i].ere});
            check($sformatf("row%0d.pc", i),    {16'h0, fetch_pc},  {16'h0, vecs[i].epc});
            if (vecs[i].ere)
                check($sformatf("row%0d.mem_addr", i), {16'h0, mem_addr}, {16'h0, vecs[i].ema});
            if (vecs[i].ev) begin
                check($sformatf("row%0d.data", i), {24'h0, out_data}, {24'h0, vecs[i].ed});
                check($sformatf("row%0d.addr", i), {16'h0, out_addr}, {16'h0, vecs[i].ea});
            end
        end
        flush = 1'b0;

        // Backpressure: exactly DEPTH reads, then issue resumes after the first pop.
        out_ready = 1'b0; flush = 1'b1; flush_addr = 16'h0010;
        step();
        flush = 1'b0;
        n_reads = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_re) n_reads++;
        end
        check("bp.reads",  n_reads,            32'd4);
        check("bp.count",  {29'h0, count},     32'd4);
        check("bp.mem_re", {31'h0, mem_re},    32'h0);
        check("bp.pc",     {16'h0, fetch_pc},  32'h0014);
        check("bp.head",   {16'h0, out_addr},  32'h0010);
        out_ready = 1'b1;
        step();
        check("bp.resume_re",   {31'h0, mem_re},   32'h1);
        check("bp.resume_addr", {16'h0, mem_addr}, 32'h0014);
        check("bp.count_after", {29'h0, count},    32'd3);
        check("bp.next_head",   {24'h0, out_data}, 32'h04);

        // Flush with 3 buffered and one read in flight.
        flush = 1'b1; flush_addr = 16'h0020;
        step();
        flush = 1'b0;
        check("fl.count", {29'h0, count},    32'h0);
        check("fl.valid", {31'h0, out_valid}, 32'h0);
        check("fl.pc",    {16'h0, fetch_pc},  32'h0020);
        steps = 0;
        while (!out_valid && steps < 6) begin
            step();
            steps++;
        end
        check("fl.latency", steps, 32'd3);
        check("fl.first_addr", {16'h0, out_addr}, 32'h0020);
        check("fl.first_data", {24'h0, out_data}, 32'h7A);
        exp_next = 16'h0021;

        // Hold for 5 cycles: drain, no issue, pc frozen, no skip on release.
        hold = 1'b1;
        frozen = fetch_pc;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            track();
            if (mem_re || fetch_pc != frozen) bad++;
        end
        check("hold.bad_cycles", bad, 32'd0);
        check("hold.count",      {29'h0, count}, 32'h0);
        check("hold.drained_to", {16'h0, exp_next}, {16'h0, frozen});
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            track();
        end
        check("hold.resumed_to", {16'h0, exp_next}, {16'h0, frozen + 16'd6});

        // Asynchronous reset with a read outstanding.
        check("rst.pre_mem_re", {31'h0, mem_re}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst.mem_re",   {31'h0, mem_re},    32'h0);
        check("rst.mem_addr", {16'h0, mem_addr},  32'h0);
        check("rst.valid",    {31'h0, out_valid}, 32'h0);
        check("rst.count",    {29'h0, count},     32'h0);
        check("rst.pc",       {16'h0, fetch_pc},  32'h0);
        check("rst.out",      {out_addr, 8'h0, out_data}, 32'h0);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_re || out_valid || count != 3'd0) bad++;
        end
        check("rst.quiet", bad, 32'd0);

        check("overflow", overflow_hits, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
